// File: rtl/tcam_pkg.sv
// Shared constants and types for the TCAM controller: sizes, command
// opcodes, FSM state encoding and the registered-command record.
package tcam_pkg;

  localparam int ENTRIES = 16;
  localparam int KEY_W   = 16;
  localparam int IDX_W   = 4;

  localparam logic [1:0] OP_SEARCH = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_INVAL  = 2'b10;
  localparam logic [1:0] OP_FLUSH  = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_WR   = 3'd1;
  localparam state_t ST_HOLD = 3'd2;
  localparam state_t ST_SRCH = 3'd3;
  localparam state_t ST_RESP = 3'd4;

  typedef struct packed {
    logic [1:0]       op;
    logic [IDX_W-1:0] idx;
  } cmd_t;

endpackage

// File: rtl/tcam_prio_enc.sv
// Lowest-index priority encoder with hit flag, purely combinational.
// Index 0 wins over all others; idx is 0 when nothing is set.
module tcam_prio_enc #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);

  // Scan downward so the last assignment is the lowest set bit.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign hit = |vec;

endmodule

// File: rtl/tcam_ctrl.sv
// TCAM sequencing controller: accepts search / write / invalidate / flush
// commands, drives an external ternary CAM, qualifies its match vector with
// per-entry valid bits and returns a held response.
// Optional: define TCAM_CTRL_MULTIHIT_EN to add the rsp_multi output.
//
// state | meaning
// IDLE  | ready for a command
// WR    | TCAM write strobe asserted
// HOLD  | write data held one more cycle, entry marked valid on exit
// SRCH  | search key on tcam_value, match vector sampled on exit
// RESP  | response held until rsp_ready
module tcam_ctrl import tcam_pkg::*; #(
  parameter int ENTRIES = tcam_pkg::ENTRIES,
  parameter int KEY_W   = tcam_pkg::KEY_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [IDX_W-1:0]   cmd_idx,
  input  logic [KEY_W-1:0]   cmd_key,
  input  logic [KEY_W-1:0]   cmd_mask,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_hit,
  output logic [IDX_W-1:0]   rsp_idx,
  output logic [ENTRIES-1:0] rsp_match,
  output logic [IDX_W-1:0]   tcam_wraddr,
  output logic [KEY_W-1:0]   tcam_value,
  output logic [KEY_W-1:0]   tcam_value2,
  output logic               tcam_wr,
  input  logic [ENTRIES-1:0] tcam_match
`ifdef TCAM_CTRL_MULTIHIT_EN
  ,
  output logic               rsp_multi
`endif
);

  state_t             state;
  cmd_t               cmd_q;
  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] qual;
  logic [ENTRIES-1:0] cmd_sel;
  logic [ENTRIES-1:0] held_sel;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_hit;
  logic               accept;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign qual      = tcam_match & valid;
  assign cmd_sel   = ENTRIES'(1) << cmd_idx;
  assign held_sel  = ENTRIES'(1) << cmd_q.idx;

  tcam_prio_enc #(
    .N     (ENTRIES),
    .IDX_W (IDX_W)
  ) u_prio (
    .vec (qual),
    .idx (enc_idx),
    .hit (enc_hit)
  );

  // Command sequencing, TCAM port drive and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cmd_q       <= '0;
      tcam_wr     <= 1'b0;
      tcam_wraddr <= '0;
      tcam_value  <= '0;
      tcam_value2 <= '0;
      rsp_valid   <= 1'b0;
      rsp_hit     <= 1'b0;
      rsp_idx     <= '0;
      rsp_match   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_q.op  <= cmd_op;
            cmd_q.idx <= cmd_idx;
            case (cmd_op)
              OP_SEARCH: begin
                tcam_value <= cmd_key;
                state      <= ST_SRCH;
              end
              OP_WRITE: begin
                tcam_wraddr <= cmd_idx;
                tcam_value  <= cmd_key;
                tcam_value2 <= cmd_mask;
                tcam_wr     <= 1'b1;
                state       <= ST_WR;
              end
              default: begin
                // Invalidate and flush answer straight away without
                // touching the TCAM ports.
                rsp_valid <= 1'b1;
                rsp_hit   <= 1'b0;
                rsp_idx   <= cmd_idx;
                rsp_match <= '0;
                state     <= ST_RESP;
              end
            endcase
          end
        end
        ST_WR: begin
          tcam_wr <= 1'b0;
          state   <= ST_HOLD;
        end
        ST_HOLD: begin
          rsp_valid <= 1'b1;
          rsp_hit   <= 1'b0;
          rsp_idx   <= cmd_q.idx;
          rsp_match <= '0;
          state     <= ST_RESP;
        end
        ST_SRCH: begin
          rsp_valid <= 1'b1;
          rsp_hit   <= enc_hit;
          rsp_idx   <= enc_idx;
          rsp_match <= qual;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          tcam_wr <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Entry valid bits: set only when a write completes, so an aborted
  // write leaves its entry invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (state == ST_HOLD) begin
      valid <= valid | held_sel;
    end else if (accept && cmd_op == OP_INVAL) begin
      valid <= valid & ~cmd_sel;
    end else if (accept && cmd_op == OP_FLUSH) begin
      valid <= '0;
    end
  end

`ifdef TCAM_CTRL_MULTIHIT_EN
  logic qual_multi;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign qual_multi = |(qual & (qual - ENTRIES'(1)));

  // Multi-hit flag: cleared on every accept, loaded when a search completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_multi <= 1'b0;
    end else if (accept) begin
      rsp_multi <= 1'b0;
    end else if (state == ST_SRCH) begin
      rsp_multi <= qual_multi;
    end
  end
`endif

endmodule
